// File: rtl/sha256_seq_pkg.sv
// Shared types and sizes for the SHA-256 block sequencer and its word packer.
package sha256_seq_pkg;

  localparam int WORDS_PER_BLOCK = 16;
  localparam int BLOCK_W         = 512;
  localparam int DIGEST_W        = 256;
  localparam int WORD_W          = 32;
  localparam int WORD_CNT_W      = $clog2(WORDS_PER_BLOCK);
  localparam int DIGEST_WORDS    = DIGEST_W / WORD_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/sha256_word_packer.sv
// Collects 32-bit message words, first word most significant, into the 512-bit block for the core.
// The write position wraps back to word 0 after the sixteenth accepted word.
module sha256_word_packer
  import sha256_seq_pkg::*;
(
  input  logic               aclk,
  input  logic               areset,
  input  logic               clear,
  input  logic               accept,
  input  logic [WORD_W-1:0]  word,
  output logic               last_word,
  output logic [BLOCK_W-1:0] block
);

  logic [WORD_CNT_W-1:0] word_cnt_reg;
  logic [WORD_W-1:0]     word_reg [WORDS_PER_BLOCK];

  // clear only rewinds the write position; stale words are overwritten before the next issue
  always_ff @(posedge aclk) begin
    if (areset) begin
      word_cnt_reg <= '0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        word_reg[i] <= '0;
      end
    end else if (clear) begin
      word_cnt_reg <= '0;
    end else if (accept) begin
      word_reg[word_cnt_reg] <= word;
      word_cnt_reg           <= word_cnt_reg + WORD_CNT_W'(1);
    end
  end

  assign last_word = (word_cnt_reg == WORD_CNT_W'(WORDS_PER_BLOCK - 1));

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_block
      assign block[BLOCK_W - 1 - WORD_W * gi -: WORD_W] = word_reg[gi];
    end
  endgenerate

endmodule

// File: rtl/sha256_block_sequencer.sv
// Feeds 512-bit blocks to an external SHA-256 core, issuing init/next pulses,
// supervising completion with a timeout and latching the returned digest.
module sha256_block_sequencer
  import sha256_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                ctrl_start,
  input  logic                ctrl_abort,
  input  logic                wr_valid,
  input  logic [WORD_W-1:0]   wr_data,
  output logic                wr_ready,
  output logic                core_init,
  output logic                core_next,
  output logic [BLOCK_W-1:0]  core_block,
  input  logic                core_ready,
  input  logic [DIGEST_W-1:0] core_digest,
  input  logic                core_digest_valid,
  input  logic [2:0]          rd_index,
  output logic [WORD_W-1:0]   rd_data,
  output logic                stat_busy,
  output logic                stat_done,
  output logic                stat_err,
  output logic [15:0]         stat_blocks
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  seq_state_e          state_reg;
  seq_state_e          state_next;
  logic                first_reg;
  logic [TMO_W-1:0]    tmo_cnt_reg;
  logic [DIGEST_W-1:0] digest_reg;
  logic [15:0]         blocks_reg;
  logic                done_reg;
  logic                err_reg;

  logic start_eff;
  logic word_accept;
  logic issue_fire;
  logic core_complete;
  logic block_done;
  logic tmo_expired;
  logic last_word;
  logic packer_clear;

  // A zero timeout count marks the first WAIT cycle, where a stale ready/valid
  // from the previous block must not be mistaken for completion.
  always_comb begin
    start_eff     = ctrl_start && !ctrl_abort && (state_reg == IDLE || state_reg == LOAD);
    word_accept   = (state_reg == LOAD) && wr_valid && !ctrl_abort && !ctrl_start;
    issue_fire    = (state_reg == ISSUE) && core_ready && !ctrl_abort;
    core_complete = (state_reg == WAIT) && (tmo_cnt_reg != '0) && core_ready && core_digest_valid;
    block_done    = core_complete && !ctrl_abort;
    tmo_expired   = (state_reg == WAIT) && !core_complete && (tmo_cnt_reg == TMO_LAST) && !ctrl_abort;
    packer_clear  = ctrl_abort || start_eff;
  end

  sha256_word_packer u_packer (
    .aclk      (aclk),
    .areset    (areset),
    .clear     (packer_clear),
    .accept    (word_accept),
    .word      (wr_data),
    .last_word (last_word),
    .block     (core_block)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (ctrl_abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ctrl_start) begin
            state_next = LOAD;
          end
        end
        LOAD: begin
          if (word_accept && last_word) begin
            state_next = ISSUE;
          end
        end
        ISSUE: begin
          if (issue_fire) begin
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (block_done) begin
            state_next = LOAD;
          end else if (tmo_expired) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Pulses are gated by reset so nothing reaches the core while it is asserted.
  always_comb begin
    wr_ready  = (state_reg == LOAD) && !areset;
    core_init = issue_fire && first_reg && !areset;
    core_next = issue_fire && !first_reg && !areset;
    stat_busy = (state_reg == ISSUE) || (state_reg == WAIT);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      first_reg   <= 1'b1;
      tmo_cnt_reg <= '0;
      digest_reg  <= '0;
      blocks_reg  <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      if (state_reg == WAIT && state_next == WAIT) begin
        tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
      end else begin
        tmo_cnt_reg <= '0;
      end

      if (ctrl_abort) begin
        done_reg <= 1'b0;
      end else if (start_eff) begin
        first_reg  <= 1'b1;
        blocks_reg <= '0;
        done_reg   <= 1'b0;
        err_reg    <= 1'b0;
      end else begin
        if (word_accept) begin
          done_reg <= 1'b0;
        end
        if (issue_fire) begin
          first_reg <= 1'b0;
        end
        if (block_done) begin
          digest_reg <= core_digest;
          done_reg   <= 1'b1;
          if (blocks_reg != 16'hFFFF) begin
            blocks_reg <= blocks_reg + 16'd1;
          end
        end
        if (tmo_expired) begin
          err_reg <= 1'b1;
        end
      end
    end
  end

  logic [WORD_W-1:0] digest_word [DIGEST_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGEST_WORDS; gi++) begin : g_digest
      assign digest_word[gi] = digest_reg[DIGEST_W - 1 - WORD_W * gi -: WORD_W];
    end
  endgenerate

  assign rd_data     = digest_word[rd_index];
  assign stat_done   = done_reg;
  assign stat_err    = err_reg;
  assign stat_blocks = blocks_reg;

endmodule
